// File: rtl/mac_result_writeback.sv
// Result writeback stage for the 3-tap MAC: requantises final accumulations,
// buffers {address, data} pairs in a small FIFO and drains them over valid/ready.
module mac_result_writeback #(
    parameter int ACCUMULATOR_WIDTH = 32,
    parameter int OUTPUT_WIDTH      = 16,
    parameter int OUTPUT_SCALE      = 0,
    parameter int FIFO_DEPTH        = 4,
    parameter int ADDR_WIDTH        = 16
) (
    input  logic                                clk,
    input  logic                                arst_in,
    input  logic                                in_valid,
    input  logic                                in_last,
    input  logic signed [ACCUMULATOR_WIDTH-1:0] acc_in,
    input  logic        [31:0]                  ch_in,
    input  logic        [ADDR_WIDTH-1:0]        base_addr,
    output logic                                mac_stall,
    output logic                                mem_we,
    output logic        [ADDR_WIDTH-1:0]        mem_addr,
    output logic signed [OUTPUT_WIDTH-1:0]      mem_wdata,
    input  logic                                mem_ready,
    output logic                                written,
    output logic        [31:0]                  write_count
);

    localparam int SW    = ACCUMULATOR_WIDTH + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int EW    = ADDR_WIDTH + OUTPUT_WIDTH;

    localparam logic signed [SW-1:0] SAT_MAX =
        {{(SW-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN =
        {{(SW-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

    logic signed [SW-1:0]           w_accExt;
    logic signed [SW-1:0]           w_shifted;
    logic signed [OUTPUT_WIDTH-1:0] w_satData;
    logic        [ADDR_WIDTH-1:0]   w_addr;
    logic        [EW-1:0]           w_entry;
    logic                           w_unusedChBits;

    logic        [PTR_W:0]          r_wrPtr;
    logic        [PTR_W:0]          r_rdPtr;
    logic        [PTR_W:0]          w_wrPtrNext;
    logic        [PTR_W:0]          w_rdPtrNext;
    logic                           w_empty;
    logic                           w_full;
    logic                           w_emptyNext;
    logic                           w_push;
    logic                           w_pop;
    logic                           w_headFromInput;
    logic        [EW-1:0]           r_mem [FIFO_DEPTH];
    logic        [ADDR_WIDTH-1:0]   r_headAddr;
    logic signed [OUTPUT_WIDTH-1:0] r_headData;
    logic                           r_written;
    logic        [31:0]             r_writeCount;

    // One extra bit of headroom so the rounding add can never overflow.
    assign w_accExt = {acc_in[ACCUMULATOR_WIDTH-1], acc_in};

    generate
        if (OUTPUT_SCALE > 0) begin : g_round
            localparam logic signed [SW-1:0] HALF = SW'(1) << (OUTPUT_SCALE - 1);
            logic signed [SW-1:0] w_rounded;
            assign w_rounded = w_accExt + HALF;
            assign w_shifted = w_rounded >>> OUTPUT_SCALE;
        end else begin : g_noRound
            assign w_shifted = w_accExt;
        end
    endgenerate

    assign w_satData = (w_shifted > SAT_MAX) ? SAT_MAX[OUTPUT_WIDTH-1:0] :
                       (w_shifted < SAT_MIN) ? SAT_MIN[OUTPUT_WIDTH-1:0] :
                                               w_shifted[OUTPUT_WIDTH-1:0];

    assign w_addr         = base_addr + ch_in[ADDR_WIDTH-1:0];
    assign w_entry        = {w_addr, w_satData};
    assign w_unusedChBits = ^ch_in;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                     (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);

    assign w_push      = in_valid && in_last && !w_full;
    assign w_pop       = !w_empty && mem_ready;
    assign w_wrPtrNext = r_wrPtr + {{PTR_W{1'b0}}, w_push};
    assign w_rdPtrNext = r_rdPtr + {{PTR_W{1'b0}}, w_pop};
    assign w_emptyNext = (w_wrPtrNext == w_rdPtrNext);

    // The next head is the entry being written this cycle when it lands in the read slot.
    assign w_headFromInput = w_push && (w_rdPtrNext == r_wrPtr);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr[PTR_W-1:0]] <= w_entry;
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_headAddr   <= '0;
            r_headData   <= '0;
            r_written    <= 1'b0;
            r_writeCount <= '0;
        end else begin
            r_wrPtr      <= w_wrPtrNext;
            r_rdPtr      <= w_rdPtrNext;
            r_written    <= w_pop;
            r_writeCount <= r_writeCount + {31'd0, w_pop};
            if (!w_emptyNext) begin
                if (w_headFromInput) begin
                    {r_headAddr, r_headData} <= w_entry;
                end else begin
                    {r_headAddr, r_headData} <= r_mem[w_rdPtrNext[PTR_W-1:0]];
                end
            end
        end
    end

    assign mac_stall   = w_full;
    assign mem_we      = !w_empty;
    assign mem_addr    = r_headAddr;
    assign mem_wdata   = r_headData;
    assign written     = r_written;
    assign write_count = r_writeCount;

endmodule
